// File: rtl/aes128_enc_ctrl.sv
// ---------------------------------------------------------------------------
// aes128_enc_ctrl -- iterative AES-128 encryption engine.
//
// One shared aes_round instance runs 10 rounds, one per clock. The round key
// is expanded on the fly from the previous one. One block is in flight at a
// time.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid (and data) until that edge. Ready never
// depends combinationally on valid.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (in_ready high only in IDLE)
//   pt_in, key_in     plaintext / cipher key, byte 0 at [127:120]
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   ct_out            ciphertext, driven straight from the state register
//   busy              high while a block is in ROUND or DONE
//   dbg_state_o       current FSM state, for debug and checker binding
// ---------------------------------------------------------------------------

// Byte substitution, table lookup. Byte 0x00 is the leftmost table entry.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a sits at bit offset (255-a)*8; for an 8-bit a, 255-a == ~a.
    assign y_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

// One AES round: SubBytes, ShiftRows, MixColumns (skipped when final_i),
// AddRoundKey. Byte i of the block is row i%4, column i/4.
module aes_round (
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         final_i,
    output logic [127:0] st_o
);
    logic [7:0] sub_b [16];
    logic [7:0] shf_b [16];
    logic [7:0] mix_b [16];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (
            .a_i (st_i[127-8*i -: 8]),
            .y_o (sub_b[i])
        );
        // Row r rotates left by r columns.
        assign shf_b[i] = sub_b[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = shf_b[4*c];
        assign a1 = shf_b[4*c+1];
        assign a2 = shf_b[4*c+2];
        assign a3 = shf_b[4*c+3];
        assign mix_b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        assign mix_b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        assign mix_b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        assign mix_b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign st_o[127-8*i -: 8] = (final_i ? shf_b[i] : mix_b[i]) ^ rk_i[127-8*i -: 8];
    end
endmodule

module aes128_enc_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic         busy,
    output logic [1:0]   dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] rk_next;
    logic [127:0] round_out;

    // Round constants for rnd 1..10; unreachable counter values give 00.
    always_comb begin
        case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Key expansion: next round key from the current one.
    assign w0    = rk_q[127:96];
    assign w1    = rk_q[95:64];
    assign w2    = rk_q[63:32];
    assign w3    = rk_q[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar k = 0; k < 4; k++) begin : g_ksb
        aes_sbox u_sbox (
            .a_i (rot_w[31-8*k -: 8]),
            .y_o (sub_w[31-8*k -: 8])
        );
    end

    assign t_w     = sub_w ^ {rcon, 24'h000000};
    assign n0      = w0 ^ t_w;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    aes_round u_round (
        .st_i    (st_q),
        .rk_i    (rk_next),
        .final_i (rnd_q == 4'd10),
        .st_o    (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = pt_in ^ key_in;
                    rk_d    = key_in;
                    rnd_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                st_d  = round_out;
                rk_d  = rk_next;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // st_q holds the ciphertext until the next accept.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == ROUND) || (state_q == DONE);
    assign ct_out      = st_q;
    assign dbg_state_o = state_q;
endmodule
